// File: rtl/spi_reg_slave_if.sv
// Register-bank bus driven by spi_reg_slave: address, write data, strobes and read data.
interface spi_reg_slave_if #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8
);
   logic [ADDR_WIDTH-1:0] reg_addr;
   logic [DATA_WIDTH-1:0] reg_wdata;
   logic [DATA_WIDTH-1:0] reg_rdata;
   logic                  write_strobe;
   logic                  read_strobe;

   modport master (
      output reg_addr,
      output reg_wdata,
      output write_strobe,
      output read_strobe,
      input  reg_rdata
   );

   modport slave (
      input  reg_addr,
      input  reg_wdata,
      input  write_strobe,
      input  read_strobe,
      output reg_rdata
   );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 target: oversampled pin decode into register-bus strobes, serial read-back on MISO.
// Optional SPI_BROADCAST_EN: chip ID 7'h7F addresses every chip for writes; broadcast reads are ignored.
module spi_reg_slave #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned RD_LATENCY = 2
) (
   input  logic       SPI_CLK,
   input  logic       RSTN,
   input  logic       SCLK,
   input  logic       SCSN,
   input  logic       MOSI,
   output logic       MISO,
   output logic       MISO_OE,
   input  logic [6:0] spi_addr,
   spi_reg_slave_if.master bus
);

   localparam int unsigned BYTE_W = 8;
`ifdef SPI_BROADCAST_EN
   localparam logic [6:0] BCAST_ID = 7'h7F;
`endif

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_IGNORE
   } state_e;

   logic [2:0]            sclk_sync_q;
   logic [1:0]            scsn_sync_q;
   logic [1:0]            mosi_sync_q;

   state_e                state_q, state_d;
   logic [2:0]            bit_cnt_q, bit_cnt_d;
   logic [6:0]            rx_sh_q, rx_sh_d;
   logic [BYTE_W-1:0]     tx_sh_q, tx_sh_d;
   logic [BYTE_W-1:0]     hold_q, hold_d;
   logic                  rw_q, rw_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic                  wr_stb_q, wr_stb_d;
   logic                  rd_stb_q, rd_stb_d;
   logic [RD_LATENCY-1:0] rd_pipe_q, rd_pipe_d;
   logic                  miso_q, miso_d;
   logic                  miso_oe_q, miso_oe_d;

   logic                  sclk_rise_c, sclk_fall_c, scsn_c, mosi_c;
   logic                  byte_done_c, id_hit_c, bcast_c;
   logic [BYTE_W-1:0]     rx_byte_c;

   // Pin synchronizers; SCLK carries a third stage for edge detection
   always_ff @(posedge SPI_CLK or negedge RSTN) begin
      if (!RSTN) begin
         sclk_sync_q <= '0;
         scsn_sync_q <= '0;
         mosi_sync_q <= '0;
      end else begin
         sclk_sync_q <= {sclk_sync_q[1:0], SCLK};
         scsn_sync_q <= {scsn_sync_q[0], SCSN};
         mosi_sync_q <= {mosi_sync_q[0], MOSI};
      end
   end

   assign sclk_rise_c = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign sclk_fall_c = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign scsn_c      = scsn_sync_q[1];
   assign mosi_c      = mosi_sync_q[1];
   assign rx_byte_c   = {rx_sh_q, mosi_c};
   assign byte_done_c = sclk_rise_c && (bit_cnt_q == 3'd7) && !scsn_c;

   always_comb begin
      id_hit_c = (rx_byte_c[6:0] == spi_addr);
      bcast_c  = 1'b0;
`ifdef SPI_BROADCAST_EN
      bcast_c  = (rx_byte_c[6:0] == BCAST_ID);
`endif
   end

   // Next-state and datapath decode
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      rx_sh_d   = rx_sh_q;
      tx_sh_d   = tx_sh_q;
      hold_d    = hold_q;
      rw_d      = rw_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      wr_stb_d  = 1'b0;
      rd_stb_d  = 1'b0;
      rd_pipe_d = RD_LATENCY'({rd_pipe_q, rd_stb_q});
      miso_oe_d = miso_oe_q;

      if (rd_pipe_q[RD_LATENCY-1]) hold_d = BYTE_W'(bus.reg_rdata);
      // Write bursts advance the address only once the strobe has been seen
      if (wr_stb_q) addr_d = addr_q + ADDR_WIDTH'(1);

      if (state_q != ST_IDLE && sclk_rise_c && !scsn_c) begin
         bit_cnt_d = bit_cnt_q + 3'd1;
         rx_sh_d   = rx_byte_c[6:0];
      end

      case (state_q)
         ST_IDLE: begin
            bit_cnt_d = 3'd0;
            miso_oe_d = 1'b0;
            if (!scsn_c) state_d = ST_CMD;
         end
         ST_CMD: begin
            if (byte_done_c) begin
               rw_d = rx_byte_c[7];
               if (bcast_c)       state_d = rx_byte_c[7] ? ST_ADDR : ST_IGNORE;
               else if (id_hit_c) state_d = ST_ADDR;
               else               state_d = ST_IGNORE;
            end
         end
         ST_ADDR: begin
            if (byte_done_c) begin
               addr_d   = ADDR_WIDTH'(rx_byte_c);
               rd_stb_d = !rw_q;
               state_d  = ST_DATA;
            end
         end
         ST_DATA: begin
            if (byte_done_c) begin
               if (rw_q) begin
                  wdata_d  = DATA_WIDTH'(rx_byte_c);
                  wr_stb_d = 1'b1;
               end else begin
                  // Reads prefetch the next byte with the address already advanced
                  addr_d   = addr_q + ADDR_WIDTH'(1);
                  rd_stb_d = 1'b1;
               end
            end
            if (!rw_q && sclk_fall_c) begin
               miso_oe_d = 1'b1;
               tx_sh_d   = (bit_cnt_q == 3'd0) ? hold_q : {tx_sh_q[6:0], 1'b0};
            end
         end
         ST_IGNORE: begin
            miso_oe_d = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase

      if (scsn_c) begin
         state_d   = ST_IDLE;
         bit_cnt_d = 3'd0;
         miso_oe_d = 1'b0;
      end

      miso_d = miso_oe_d & tx_sh_d[7];
   end

   always_ff @(posedge SPI_CLK or negedge RSTN) begin
      if (!RSTN) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= '0;
         rx_sh_q   <= '0;
         tx_sh_q   <= '0;
         hold_q    <= '0;
         rw_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         wr_stb_q  <= 1'b0;
         rd_stb_q  <= 1'b0;
         rd_pipe_q <= '0;
         miso_q    <= 1'b0;
         miso_oe_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         rx_sh_q   <= rx_sh_d;
         tx_sh_q   <= tx_sh_d;
         hold_q    <= hold_d;
         rw_q      <= rw_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         wr_stb_q  <= wr_stb_d;
         rd_stb_q  <= rd_stb_d;
         rd_pipe_q <= rd_pipe_d;
         miso_q    <= miso_d;
         miso_oe_q <= miso_oe_d;
      end
   end

   assign MISO             = miso_q;
   assign MISO_OE          = miso_oe_q;
   assign bus.reg_addr     = addr_q;
   assign bus.reg_wdata    = wdata_q;
   assign bus.write_strobe = wr_stb_q;
   assign bus.read_strobe  = rd_stb_q;

endmodule
